// File: rtl/hazard_ctrl_pkg.sv
// Shared hazard-unit definitions: FSM state encoding, flush-length limits and
// the instruction-class constants the hazard rules are phrased in.
package hazard_ctrl_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FLUSH   = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    localparam int FLUSH_CYC_MIN = 1;
    localparam int FLUSH_CYC_MAX = 7;
    localparam int FLUSH_CNT_W   = 3;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_e;

endpackage

// File: rtl/hazard_flush_ctr.sv
// Pipeline sequencing FSM: branch flush countdown and data-memory wait,
// producing the global stall and the "EX is being flushed" indication.
module hazard_flush_ctr
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ready,
    input  logic ex_jmp_vld,
    output logic stall_all,
    output logic in_flush
);

    localparam logic [FLUSH_CNT_W-1:0] RELOAD = FLUSH_CNT_W'(FLUSH_CYC - 1);
    localparam logic [1:0] ST_AFTER_BRANCH = (FLUSH_CYC == 1) ? ST_RUN : ST_FLUSH;

    if (FLUSH_CYC < FLUSH_CYC_MIN || FLUSH_CYC > FLUSH_CYC_MAX) begin : g_bad_flush_cyc
        $error("hazard_flush_ctr: FLUSH_CYC out of range");
    end

    logic [1:0]             state;
    logic [1:0]             prior;
    logic [1:0]             eff_state;
    logic [FLUSH_CNT_W-1:0] cnt;

    assign stall_all = (mem_req & ~mem_ready) | ((state == ST_MEMWAIT) & ~mem_ready);

    // The release cycle of a memory wait already behaves as the interrupted state,
    // so a flush resumes there and counts it as one of its unstalled cycles.
    assign eff_state = (state == ST_MEMWAIT) ? prior : state;
    assign in_flush  = (eff_state == ST_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            prior <= ST_RUN;
            cnt   <= '0;
        end else if (stall_all) begin
            if (state != ST_MEMWAIT) begin
                prior <= state;
                state <= ST_MEMWAIT;
            end
        end else if (ex_jmp_vld) begin
            cnt   <= RELOAD;
            state <= ST_AFTER_BRANCH;
        end else if (in_flush) begin
            cnt   <= (cnt == '0) ? '0 : cnt - 1'b1;
            state <= (cnt <= FLUSH_CNT_W'(1)) ? ST_RUN : ST_FLUSH;
        end else begin
            state <= eff_state;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, jump redirect priority,
// branch flush and memory-wait stall, plus a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAW       = 5,
    parameter int FLUSH_CYC = 2,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RAW-1:0]    id_rs1,
    input  logic [RAW-1:0]    id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [RAW-1:0]    ex_rd,
    input  logic              ex_is_load,
    input  logic              id_jmp_vld,
    input  logic [XLEN-1:0]   id_jmp_addr,
    input  logic              ex_jmp_vld,
    input  logic [XLEN-1:0]   ex_jmp_addr,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              hold_if,
    output logic              nop_id,
    output logic              stall_all,
    output logic              jmp_vld_if,
    output logic [XLEN-1:0]   jmp_addr_if,
    output logic              inst_vld_ex,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    logic in_flush;
    logic load_use_hit;
    logic load_use_eff;

    hazard_flush_ctr #(
        .FLUSH_CYC (FLUSH_CYC)
    ) u_flush_ctr (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_ready  (mem_ready),
        .ex_jmp_vld (ex_jmp_vld),
        .stall_all  (stall_all),
        .in_flush   (in_flush)
    );

    assign load_use_hit = ex_is_load & (ex_rd != '0) &
                          ((id_rs1_used & (id_rs1 == ex_rd)) |
                           (id_rs2_used & (id_rs2 == ex_rd)));

    // The ID instruction is about to be squashed anyway, so no bubble is needed.
    assign load_use_eff = load_use_hit & ~ex_jmp_vld & ~in_flush;

    assign hold_if     = stall_all | load_use_eff;
    assign nop_id      = ~stall_all & load_use_eff;
    assign jmp_vld_if  = ~stall_all & (ex_jmp_vld | id_jmp_vld);
    assign inst_vld_ex = ~(ex_jmp_vld | in_flush);

    always_comb begin
        jmp_addr_if = '0;
        if (jmp_vld_if) begin
            jmp_addr_if = ex_jmp_vld ? ex_jmp_addr : id_jmp_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (hold_if && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run
// against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

    localparam int XLEN      = 32;
    localparam int RAW       = 5;
    localparam int FLUSH_CYC = 2;
    localparam int PERF_W    = 4;
    localparam int PERF_MAX  = (1 << PERF_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [RAW-1:0]    id_rs1, id_rs2, ex_rd;
    logic              id_rs1_used, id_rs2_used, ex_is_load;
    logic              id_jmp_vld, ex_jmp_vld;
    logic [XLEN-1:0]   id_jmp_addr, ex_jmp_addr;
    logic              mem_req, mem_ready;
    logic              hold_if, nop_id, stall_all, jmp_vld_if, inst_vld_ex;
    logic [XLEN-1:0]   jmp_addr_if;
    logic [PERF_W-1:0] perf_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining flushed cycles, memory-wait flag, stall count.
    int m_flush_left;
    bit m_mem_wait;
    int m_perf;
    bit e_stall, e_hold, e_nop, e_jv, e_ivx;
    logic [XLEN-1:0] e_ja;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .XLEN(XLEN), .RAW(RAW), .FLUSH_CYC(FLUSH_CYC), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .id_jmp_vld(id_jmp_vld), .id_jmp_addr(id_jmp_addr),
        .ex_jmp_vld(ex_jmp_vld), .ex_jmp_addr(ex_jmp_addr),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .hold_if(hold_if), .nop_id(nop_id), .stall_all(stall_all),
        .jmp_vld_if(jmp_vld_if), .jmp_addr_if(jmp_addr_if),
        .inst_vld_ex(inst_vld_ex), .perf_stall_cnt(perf_stall_cnt)
    );

    task automatic model_eval();
        bit hit, flushing;
        if (rst) begin
            m_flush_left = 0;
            m_mem_wait   = 0;
            m_perf       = 0;
        end
        flushing = (m_flush_left > 0);
        e_stall  = (mem_req && !mem_ready) || (m_mem_wait && !mem_ready);
        hit = ex_is_load && (ex_rd != 0) &&
              ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        hit     = hit && !ex_jmp_vld && !flushing;
        e_hold  = e_stall || hit;
        e_nop   = !e_stall && hit;
        e_jv    = !e_stall && (ex_jmp_vld || id_jmp_vld);
        e_ja    = !e_jv ? '0 : (ex_jmp_vld ? ex_jmp_addr : id_jmp_addr);
        e_ivx   = !(ex_jmp_vld || flushing);
    endtask

    task automatic model_commit();
        if (rst) begin
            m_flush_left = 0;
            m_mem_wait   = 0;
            m_perf       = 0;
        end else begin
            if (e_stall) begin
                m_mem_wait = 1;
            end else begin
                m_mem_wait = 0;
                if (ex_jmp_vld) m_flush_left = FLUSH_CYC - 1;
                else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
            end
            if (e_hold && m_perf < PERF_MAX) m_perf = m_perf + 1;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 0; id_rs2_used = 0; ex_is_load = 0;
        id_jmp_vld = 0; ex_jmp_vld = 0;
        id_jmp_addr = '0; ex_jmp_addr = '0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            idle();
            ex_jmp_vld  = i[0];
            ex_jmp_addr = $urandom;
            #1;
            checks++;
            if (inst_vld_ex !== !ex_jmp_vld) begin
                errors++;
                $display("FAIL rst_ivx got %b exp %b", inst_vld_ex, !ex_jmp_vld);
            end
            checks++;
            if (perf_stall_cnt !== '0) begin
                errors++;
                $display("FAIL rst_perf got %0d exp 0", perf_stall_cnt);
            end
            tick();
        end
        rst = 0;
        idle();
        #1;
        checks++;
        if (stall_all !== 1'b0 || hold_if !== 1'b0 || inst_vld_ex !== 1'b1) begin
            errors++;
            $display("FAIL rst_release got stall=%b hold=%b ivx=%b exp 0 0 1",
                     stall_all, hold_if, inst_vld_ex);
        end
    endtask

    task automatic test_load_use();
        idle();
        ex_is_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1;
        id_rs2 = 5'd7; id_rs2_used = 1;
        #1;
        checks++;
        if (hold_if !== 1'b1 || nop_id !== 1'b1 || perf_stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL lu_hit got hold=%b nop=%b perf=%0d exp 1 1 0",
                     hold_if, nop_id, perf_stall_cnt);
        end
        tick();
        idle();
        #1;
        checks++;
        if (hold_if !== 1'b0 || nop_id !== 1'b0 || perf_stall_cnt !== 4'd1) begin
            errors++;
            $display("FAIL lu_after got hold=%b nop=%b perf=%0d exp 0 0 1",
                     hold_if, nop_id, perf_stall_cnt);
        end
        ex_is_load = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1;
        #1;
        checks++;
        if (hold_if !== 1'b0 || nop_id !== 1'b0) begin
            errors++;
            $display("FAIL lu_x0 got hold=%b nop=%b exp 0 0", hold_if, nop_id);
        end
        ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_used = 0; id_rs2 = 5'd9; id_rs2_used = 0;
        #1;
        checks++;
        if (hold_if !== 1'b0) begin
            errors++;
            $display("FAIL lu_unused got hold=%b exp 0", hold_if);
        end
        id_rs2_used = 1;
        #1;
        checks++;
        if (hold_if !== 1'b1 || nop_id !== 1'b1) begin
            errors++;
            $display("FAIL lu_rs2 got hold=%b nop=%b exp 1 1", hold_if, nop_id);
        end
        ex_is_load = 0;
        #1;
        checks++;
        if (hold_if !== 1'b0) begin
            errors++;
            $display("FAIL lu_notload got hold=%b exp 0", hold_if);
        end
        tick();
    endtask

    task automatic test_branch_flush();
        idle();
        ex_jmp_vld = 1; ex_jmp_addr = 32'h100;
        #1;
        checks++;
        if (jmp_vld_if !== 1'b1 || jmp_addr_if !== 32'h100 || inst_vld_ex !== 1'b0) begin
            errors++;
            $display("FAIL br_take got vld=%b addr=%h ivx=%b exp 1 100 0",
                     jmp_vld_if, jmp_addr_if, inst_vld_ex);
        end
        tick();
        idle();
        ex_is_load = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_rs1_used = 1;
        #1;
        checks++;
        if (inst_vld_ex !== 1'b0 || hold_if !== 1'b0 || nop_id !== 1'b0) begin
            errors++;
            $display("FAIL br_flush got ivx=%b hold=%b nop=%b exp 0 0 0",
                     inst_vld_ex, hold_if, nop_id);
        end
        tick();
        idle();
        #1;
        checks++;
        if (inst_vld_ex !== 1'b1 || jmp_vld_if !== 1'b0 || jmp_addr_if !== '0) begin
            errors++;
            $display("FAIL br_done got ivx=%b vld=%b addr=%h exp 1 0 0",
                     inst_vld_ex, jmp_vld_if, jmp_addr_if);
        end
        ex_jmp_vld = 1; ex_jmp_addr = 32'h100; id_jmp_vld = 1; id_jmp_addr = 32'h200;
        ex_is_load = 1; ex_rd = 5'd4; id_rs2 = 5'd4; id_rs2_used = 1;
        #1;
        checks++;
        if (jmp_vld_if !== 1'b1 || jmp_addr_if !== 32'h100 || hold_if !== 1'b0) begin
            errors++;
            $display("FAIL br_prio got vld=%b addr=%h hold=%b exp 1 100 0",
                     jmp_vld_if, jmp_addr_if, hold_if);
        end
        tick();
        idle();
        ex_jmp_vld = 1; ex_jmp_addr = 32'h180;
        #1;
        tick();
        idle();
        #1;
        checks++;
        if (inst_vld_ex !== 1'b0) begin
            errors++;
            $display("FAIL br_restart got ivx=%b exp 0", inst_vld_ex);
        end
        tick();
        checks++;
        if (inst_vld_ex !== 1'b1) begin
            errors++;
            $display("FAIL br_restart_end got ivx=%b exp 1", inst_vld_ex);
        end
        id_jmp_vld = 1; id_jmp_addr = 32'h240;
        #1;
        checks++;
        if (jmp_vld_if !== 1'b1 || jmp_addr_if !== 32'h240 || inst_vld_ex !== 1'b1) begin
            errors++;
            $display("FAIL id_jmp got vld=%b addr=%h ivx=%b exp 1 240 1",
                     jmp_vld_if, jmp_addr_if, inst_vld_ex);
        end
        tick();
        idle();
    endtask

    task automatic test_stall_in_flush();
        idle();
        ex_jmp_vld = 1; ex_jmp_addr = 32'h300;
        #1;
        tick();
        for (int i = 0; i < 3; i++) begin
            idle();
            mem_req = (i == 0); mem_ready = 0;
            id_jmp_vld = 1; id_jmp_addr = 32'h44;
            #1;
            checks++;
            if (stall_all !== 1'b1 || hold_if !== 1'b1 || nop_id !== 1'b0 ||
                jmp_vld_if !== 1'b0 || inst_vld_ex !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d got stall=%b hold=%b nop=%b jv=%b ivx=%b exp 1 1 0 0 0",
                         i, stall_all, hold_if, nop_id, jmp_vld_if, inst_vld_ex);
            end
            tick();
        end
        idle();
        mem_ready = 1;
        #1;
        checks++;
        if (stall_all !== 1'b0 || inst_vld_ex !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got stall=%b ivx=%b exp 0 0", stall_all, inst_vld_ex);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_all !== 1'b0 || inst_vld_ex !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume got stall=%b ivx=%b exp 0 1", stall_all, inst_vld_ex);
        end
    endtask

    task automatic test_reset_mid_op();
        idle();
        ex_jmp_vld = 1; ex_jmp_addr = 32'h500;
        #1;
        tick();
        idle();
        #1;
        checks++;
        if (inst_vld_ex !== 1'b0) begin
            errors++;
            $display("FAIL mid_flush got ivx=%b exp 0", inst_vld_ex);
        end
        rst = 1;
        #1;
        tick();
        rst = 0;
        #1;
        checks++;
        if (inst_vld_ex !== 1'b1 || perf_stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_flush got ivx=%b perf=%0d exp 1 0", inst_vld_ex, perf_stall_cnt);
        end
        mem_req = 1; mem_ready = 0;
        #1;
        tick();
        mem_req = 0;
        #1;
        checks++;
        if (stall_all !== 1'b1) begin
            errors++;
            $display("FAIL mid_memwait got stall=%b exp 1", stall_all);
        end
        rst = 1;
        #1;
        checks++;
        if (stall_all !== 1'b0 || perf_stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_memwait got stall=%b perf=%0d exp 0 0", stall_all, perf_stall_cnt);
        end
        tick();
        rst = 0;
        idle();
        #1;
    endtask

    task automatic test_perf_saturate();
        rst = 1;
        idle();
        #1;
        tick();
        rst = 0;
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            tick();
            checks++;
            if (perf_stall_cnt !== PERF_W'((k > PERF_MAX) ? PERF_MAX : k)) begin
                errors++;
                $display("FAIL perf_%0d got %0d exp %0d", k, perf_stall_cnt,
                         (k > PERF_MAX) ? PERF_MAX : k);
            end
        end
        idle();
        mem_ready = 1;
        #1;
        tick();
        idle();
        #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 79) == 0);
            mem_req     = ($urandom_range(0, 3) == 0);
            mem_ready   = ($urandom_range(0, 1) == 1);
            ex_jmp_vld  = ($urandom_range(0, 6) == 0);
            id_jmp_vld  = ($urandom_range(0, 4) == 0);
            ex_jmp_addr = $urandom;
            id_jmp_addr = $urandom;
            ex_is_load  = ($urandom_range(0, 1) == 1);
            ex_rd       = RAW'($urandom_range(0, 3));
            id_rs1      = RAW'($urandom_range(0, 3));
            id_rs2      = RAW'($urandom_range(0, 3));
            id_rs1_used = ($urandom_range(0, 1) == 1);
            id_rs2_used = ($urandom_range(0, 1) == 1);
            #1;
            model_eval();
            checks++;
            if (stall_all !== e_stall || hold_if !== e_hold || nop_id !== e_nop ||
                jmp_vld_if !== e_jv || jmp_addr_if !== e_ja || inst_vld_ex !== e_ivx ||
                perf_stall_cnt !== PERF_W'(m_perf)) begin
                errors++;
                $display("FAIL rnd_%0d got st=%b h=%b n=%b jv=%b ja=%h iv=%b pc=%0d exp %b %b %b %b %h %b %0d",
                         n, stall_all, hold_if, nop_id, jmp_vld_if, jmp_addr_if, inst_vld_ex,
                         perf_stall_cnt, e_stall, e_hold, e_nop, e_jv, e_ja, e_ivx, m_perf);
            end
            tick();
        end
        rst = 0;
        idle();
        #1;
    endtask

    initial begin
        rst = 1;
        idle();
        m_flush_left = 0;
        m_mem_wait   = 0;
        m_perf       = 0;
        @(negedge clk);
        #1;
        test_reset();
        test_load_use();
        test_branch_flush();
        test_stall_in_flush();
        test_reset_mid_op();
        test_perf_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  XLEN, 32, jump address width
  RAW, 5, register index width
  FLUSH_CYC, 2, cycles inst_vld_ex is low after a taken EX branch (legal 1..7)
  PERF_W, 16, stall counter width
REQ-002 Ports SHALL be (name direction width meaning):
  clk  in  1  single clock
  rst  in  1  reset, asynchronous, active-high
  id_rs1, id_rs2  in  RAW  ID-stage source registers
  id_rs1_used, id_rs2_used  in  1  source actually read by ID instruction
  ex_rd  in  RAW  EX-stage destination register
  ex_is_load  in  1  EX instruction is any load (LB/LH/LW/LBU/LHU)
  id_jmp_vld  in  1  unconditional jump resolved in ID
  id_jmp_addr  in  XLEN  its target
  ex_jmp_vld  in  1  taken conditional branch resolved in EX
  ex_jmp_addr  in  XLEN  its target
  mem_req, mem_ready  in  1  data-memory request / completion
  hold_if  out  1  freeze PC and IF/ID register
  nop_id  out  1  inject bubble into ID/EX register
  stall_all  out  1  freeze every pipeline register
  jmp_vld_if, jmp_addr_if  out  1, XLEN  PC redirect
  inst_vld_ex  out  1  EX instruction may commit
  perf_stall_cnt  out  PERF_W  stall cycles since reset

Function
REQ-003 Load-use hit SHALL be ex_is_load AND ex_rd!=0 AND ((id_rs1_used AND id_rs1==ex_rd) OR (id_rs2_used AND id_rs2==ex_rd)).
REQ-004 On a hit, hold_if and nop_id SHALL be 1 for exactly that cycle (one-bubble penalty), combinationally.
REQ-005 FSM states SHALL be RUN, FLUSH, MEMWAIT; reset state RUN.
REQ-006 RUN->MEMWAIT when mem_req=1 and mem_ready=0; MEMWAIT->prior state (RUN or FLUSH) in the cycle after mem_ready=1.
REQ-007 stall_all SHALL equal (mem_req AND NOT mem_ready) OR state==MEMWAIT with mem_ready=0; while stall_all=1, hold_if=1, nop_id=0, jmp_vld_if=0, and the FSM/flush counter SHALL freeze.
REQ-008 Redirect priority: ex_jmp_vld (addr ex_jmp_addr) > id_jmp_vld (addr id_jmp_addr) > none (jmp_vld_if=0, jmp_addr_if=0).
REQ-009 Taken EX branch with stall_all=0 SHALL load flush counter with FLUSH_CYC-1 and go to FLUSH (RUN if FLUSH_CYC=1); inst_vld_ex SHALL be 0 in that cycle.
REQ-010 In FLUSH inst_vld_ex SHALL be 0; counter decrements per unstalled cycle; FLUSH->RUN when counter is 0.
REQ-011 inst_vld_ex=0 in total for exactly FLUSH_CYC unstalled cycles per taken branch.
REQ-012 A new ex_jmp_vld while in FLUSH SHALL reload the counter (restart, not extend additively).
REQ-013 Load-use hit SHALL be suppressed (hold_if=nop_id=0) when ex_jmp_vld=1 or state==FLUSH.
REQ-014 perf_stall_cnt SHALL increment each cycle hold_if=1, saturating at all-ones.

Reset
REQ-015 While rst=1: state RUN, flush counter 0, perf_stall_cnt 0; combinational outputs follow REQ-003..010 from that state (inst_vld_ex = NOT ex_jmp_vld).
REQ-016 Reset asserted mid-FLUSH or mid-MEMWAIT SHALL abort immediately; first cycle after release behaves as RUN.

Structure
REQ-017 FSM state encoding, FLUSH_CYC legal range and instruction-class constants SHALL live in the shared core defines package.
REQ-018 Flush counter plus FSM MAY be a sub-module hazard_flush_ctr; everything else flat.

Verification
REQ-019 LW x5 in EX, ID ADD reads x5 (rs1_used=1) -> hold_if=nop_id=1 one cycle, perf_stall_cnt 0->1; same with ex_rd=0 -> no stall.
REQ-020 ex_jmp_vld=1, addr 0x100, FLUSH_CYC=2 -> jmp_vld_if=1, jmp_addr_if=0x100, inst_vld_ex=0 two cycles, then 1.
REQ-021 ex_jmp_vld and id_jmp_vld same cycle (0x100 / 0x200) -> jmp_addr_if=0x100.
REQ-022 mem_req=1, mem_ready=0 for 3 cycles during FLUSH -> stall_all=1 three cycles, counter frozen, inst_vld_ex low for FLUSH_CYC unstalled cycles in total.
REQ-023 rst pulsed mid-FLUSH -> inst_vld_ex=1 the cycle after release, perf_stall_cnt=0.
REQ-024 PERF_W=4, 20 consecutive stall cycles -> perf_stall_cnt holds 15.
